// File: rtl/sha_msg_schedule.sv
// SHA-256 message-schedule expander: takes the 16 words of one block, then streams W0..W63
// through a single-entry valid/ready output register.
module sha_msg_schedule #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [DATA_W-1:0] in0,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out0,
   output logic [5:0]        out_idx,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_EXPAND,
      S_DONE
   } state_e;

   state_e                    state_q, state_d;
   logic [15:0][DATA_W-1:0]   w_q;
   logic [5:0]                t_q;
   logic [DATA_W-1:0]         out0_q;
   logic [5:0]                out_idx_q;
   logic                      out_valid_q;
   logic                      done_q;

   logic                      free;
   logic                      clear;
   logic                      load_en;
   logic [DATA_W-1:0]         load_word;
   logic [DATA_W-1:0]         expand_word;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // w_q[0] is the oldest word (W[t-16]), w_q[15] the newest (W[t-1])
   assign expand_word = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
   assign free        = !out_valid_q || out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (run) state_d = S_LOAD;
         S_LOAD:   if (load_en && t_q == 6'd15) state_d = S_EXPAND;
         S_EXPAND: if (load_en && t_q == 6'd63) state_d = S_DONE;
         S_DONE:   if (out_valid_q && out_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      clear     = 1'b0;
      load_en   = 1'b0;
      load_word = '0;
      unique case (state_q)
         S_IDLE: clear = run;
         S_LOAD: begin
            in_ready  = free;
            load_en   = in_valid && free;
            load_word = in0;
         end
         S_EXPAND: begin
            load_en   = free;
            load_word = expand_word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_q         <= '0;
         t_q         <= '0;
         out0_q      <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= (state_q == S_DONE) && out_valid_q && out_ready;
         if (clear) begin
            w_q <= '0;
            t_q <= '0;
         end else if (load_en) begin
            w_q <= {load_word, w_q[15:1]};
            t_q <= t_q + 6'd1;
         end
         // a load in the same cycle as a consume replaces the word with no bubble
         if (load_en) begin
            out0_q      <= load_word;
            out_idx_q   <= t_q;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out0      = out0_q;
   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule: abc / zero blocks, backpressure, input gaps,
// ignored run, and mid-stream reset.
module tb_sha_msg_schedule;

   logic        clk = 1'b0;
   logic        rst, run, in_valid, in_ready, out_valid, out_ready, done;
   logic [31:0] in0, out0;
   logic [5:0]  out_idx;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] blk   [16];
   logic [31:0] ref_w [64];

   always #5 clk = ~clk;

   sha_msg_schedule #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .in0       (in0),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out0      (out0),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic build_ref();
      for (int t = 0; t < 64; t++) begin
         if (t < 16) ref_w[t] = blk[t];
         else ref_w[t] = (ror(ref_w[t-2], 17) ^ ror(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                       + ref_w[t-7]
                       + (ror(ref_w[t-15], 7) ^ ror(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                       + ref_w[t-16];
      end
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   task automatic set_zero();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, ":in_ready"},  in_ready,  0);
      chk({nm, ":out_valid"}, out_valid, 0);
      chk({nm, ":out0"},      out0,      0);
      chk({nm, ":out_idx"},   out_idx,   0);
      chk({nm, ":done"},      done,      0);
   endtask

   // run one block; bp = stalling consumer, gap = 3-cycle hole after W5,
   // run_at / rst_at = output index after whose handshake run is pulsed / reset asserted
   task automatic stream(input string nm, input bit abc, input bit bp, input bit gap,
                         input int run_at, input int rst_at);
      int k = 0, n = 0, cyc = 0, gap_left = 3, first_cyc = -1, last_cyc = -1;
      bit exp_done = 0, seen_done = 0, prev_stall = 0, saw_bubble = 0;
      bit pulse_run = 0, do_rst = 0;
      logic [31:0] hold_o;
      logic [5:0]  hold_i;
      build_ref();
      @(posedge clk); #1;
      run = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk({nm, ":idle_in_ready"}, in_ready, 0);
      @(posedge clk); #1;
      run = 1'b0;
      while (!seen_done && cyc < 600) begin
         run       = pulse_run;
         pulse_run = 0;
         if (gap && k == 6 && gap_left > 0) begin
            in_valid = 1'b0;
            gap_left--;
         end else begin
            in_valid = (k < 16);
         end
         in0       = (k < 16) ? blk[k] : 32'h0;
         out_ready = bp ? ((cyc % 7 != 3) && ($urandom_range(0, 3) != 0)) : 1'b1;

         @(negedge clk);
         if (cyc == 0) chk({nm, ":first_in_ready"}, in_ready, 1);
         if (prev_stall) begin
            chk({nm, ":stall_out0"},    out0,    hold_o);
            chk({nm, ":stall_out_idx"}, out_idx, hold_i);
         end
         chk({nm, ":done"}, done, exp_done);
         if (exp_done) chk({nm, ":valid_after_done"}, out_valid, 0);
         if (done) seen_done = 1;
         exp_done = 0;
         if (out_valid && !out_ready) begin
            chk({nm, ":stall_in_ready"}, in_ready, 0);
            prev_stall = 1;
            hold_o     = out0;
            hold_i     = out_idx;
         end else begin
            prev_stall = 0;
         end
         if (!out_valid && n > 0 && n < 16) saw_bubble = 1;
         if (in_valid && in_ready) k++;
         if (out_valid && out_ready) begin
            if (n < 64) begin
               chk({nm, ":out_idx"}, out_idx, n);
               chk({nm, ":out0"},    out0,    ref_w[n]);
               if (abc && n == 16) chk({nm, ":W16"}, out0, 32'h61626380);
               if (abc && n == 17) chk({nm, ":W17"}, out0, 32'h000F0000);
               if (abc && n == 18) chk({nm, ":W18"}, out0, 32'h7DA86405);
               if (!abc) chk({nm, ":zero_word"}, out0, 32'h0);
            end else begin
               chk({nm, ":extra_word"}, 1, 0);
            end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (n == 63)     exp_done  = 1;
            if (n == run_at) pulse_run = 1;
            if (n == rst_at) do_rst    = 1;
            n++;
         end
         @(posedge clk); #1;
         cyc++;
         if (do_rst) begin
            rst = 1'b0;
            run = 1'b0;
            break;
         end
      end
      if (!do_rst) begin
         chk({nm, ":done_seen"}, seen_done, 1);
         chk({nm, ":word_count"}, n, 64);
         if (!bp && !gap) chk({nm, ":span"}, last_cyc - first_cyc, 63);
         if (gap) chk({nm, ":gap_bubble"}, saw_bubble, 1);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; run = 1'b0; in_valid = 1'b0; in0 = 32'h0; out_ready = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      set_abc();  stream("abc",  1, 0, 0, -1, -1);
      set_zero(); stream("zero", 0, 0, 0, -1, -1);
      set_abc();  stream("abc2", 1, 0, 0, -1, -1);
      stream("bp",    1, 1, 0, -1, -1);
      stream("gap",   1, 0, 1, -1, -1);
      stream("run30", 1, 0, 0, 30, -1);

      stream("rst40", 1, 0, 0, -1, 40);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_reset_outputs("mid_reset");
         @(posedge clk); #1;
      end
      rst = 1'b1;
      stream("after_rst", 1, 0, 0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
